// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants: load sizes, special register indices, SP reset value
package cpu_defs;

    localparam logic [1:0]  SIZE_WORD    = 2'b00;
    localparam logic [1:0]  SIZE_HALF    = 2'b01;
    localparam logic [1:0]  SIZE_BYTE    = 2'b10;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [31:0] SP_RESET_VAL = 32'd227;

endpackage

// File: rtl/load_size_ext.sv
// rtl/load_size_ext.sv - combinational load sizing (byte/half/word, signed or unsigned)
module load_size_ext
    import cpu_defs::*;
(
    input  logic [31:0] write_data,
    input  logic [1:0]  write_size,
    input  logic        write_signed,
    output logic [31:0] sized_data
);

    always_comb begin
        sized_data = write_data;
        case (write_size)
            SIZE_HALF: sized_data = {{16{write_signed & write_data[15]}}, write_data[15:0]};
            SIZE_BYTE: sized_data = {{24{write_signed & write_data[7]}}, write_data[7:0]};
            SIZE_WORD: sized_data = write_data;
            // 2'b11 is reserved and behaves as a word write
            default:   sized_data = write_data;
        endcase
    end

endmodule

// File: rtl/banco_reg_wb.sv
// rtl/banco_reg_wb.sv - 32x32 register bank write-back endpoint; REGFILE_BYPASS_EN enables write-through forwarding
module banco_reg_wb
    import cpu_defs::*;
#(
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = SP_RESET_VAL,
    parameter int          NREGS    = 32
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [1:0]  write_size,
    input  logic        write_signed,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic        wb_valid,
    output logic [4:0]  wb_reg
);

    logic [31:0] sized_data;
    logic        commit;
    // index 0 is hard-wired to zero, so it has no storage
    logic [31:0] regs [1:NREGS-1];

    load_size_ext u_load_size_ext (
        .write_data   (write_data),
        .write_size   (write_size),
        .write_signed (write_signed),
        .sized_data   (sized_data)
    );

    assign commit = reg_write && (write_reg != REG_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
            end
            wb_valid <= 1'b0;
            wb_reg   <= 5'd0;
        end else begin
            wb_valid <= commit;
            if (commit) begin
                regs[write_reg] <= sized_data;
                wb_reg          <= write_reg;
            end
        end
    end

    always_comb begin
        read_data1 = 32'd0;
        read_data2 = 32'd0;
        if (read_reg1 != REG_ZERO) read_data1 = regs[read_reg1];
        if (read_reg2 != REG_ZERO) read_data2 = regs[read_reg2];
`ifdef REGFILE_BYPASS_EN
        // forward the same sized value that will be stored, so both views agree
        if (commit && (read_reg1 == write_reg)) read_data1 = sized_data;
        if (commit && (read_reg2 == write_reg)) read_data2 = sized_data;
`else
`endif
    end

endmodule

// File: tb/tb_banco_reg_wb.sv
// tb/tb_banco_reg_wb.sv - scoreboard testbench for banco_reg_wb
module tb_banco_reg_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  write_size;
    logic        write_signed;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_valid;
    logic [4:0]  wb_reg;

    banco_reg_wb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_size   (write_size),
        .write_signed (write_signed),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int    compared   = 0;
    int    mismatched = 0;
    event  sample_ev;

    task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
        item_t it;
        it.name = nm;
        it.sel  = sel;
        it.exp  = v;
        q.push_back(it);
    endtask

    task automatic check_now();
        #1;
        ->sample_ev;
        #1;
    endtask

    // monitor: drains the scoreboard whenever the stimulus presents a sample point
    initial begin
        item_t       it;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.sel)
                    0:       act = read_data1;
                    1:       act = read_data2;
                    2:       act = {31'd0, wb_valid};
                    default: act = {27'd0, wb_reg};
                endcase
                compared++;
                if (act !== it.exp) begin
                    mismatched++;
                    $display("FAIL %s actual=%h required=%h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic do_write(input logic [4:0] r, input logic [31:0] d,
                            input logic [1:0] sz, input logic sg);
        @(negedge clk);
        reg_write    = 1'b1;
        write_reg    = r;
        write_data   = d;
        write_size   = sz;
        write_signed = sg;
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
        read_reg1 = a;
        read_reg2 = b;
    endtask

    initial begin
        reset_n      = 1'b0;
        reg_write    = 1'b0;
        write_reg    = 5'd0;
        write_data   = 32'd0;
        write_size   = 2'b00;
        write_signed = 1'b0;
        read_reg1    = 5'd29;
        read_reg2    = 5'd0;

        // reset state
        repeat (2) @(negedge clk);
        expect_val("rst_sp", 0, 32'd227);
        expect_val("rst_r0", 1, 32'd0);
        expect_val("rst_wbv", 2, 32'd0);
        expect_val("rst_wbr", 3, 32'd0);
        check_now();
        reset_n = 1'b1;

        // dirty two registers, then pulse reset between edges
        do_write(5'd29, 32'd1, 2'b00, 1'b0);
        do_write(5'd5, 32'd7, 2'b00, 1'b0);
        set_reads(5'd29, 5'd5);
        expect_val("pre_rst_sp", 0, 32'd1);
        expect_val("pre_rst_r5", 1, 32'd7);
        check_now();
        reset_n = 1'b0;
        expect_val("pulse_sp", 0, 32'd227);
        expect_val("pulse_r5", 1, 32'd0);
        expect_val("pulse_wbv", 2, 32'd0);
        check_now();
        reset_n = 1'b1;

        // word write
        do_write(5'd8, 32'hDEADBEEF, 2'b00, 1'b0);
        set_reads(5'd8, 5'd8);
        expect_val("word_rd1", 0, 32'hDEADBEEF);
        expect_val("word_rd2", 1, 32'hDEADBEEF);
        expect_val("word_wbv", 2, 32'd1);
        expect_val("word_wbr", 3, 32'd8);
        check_now();

        // sizing
        do_write(5'd11, 32'h0000_80F0, 2'b10, 1'b1);
        do_write(5'd12, 32'h0000_80F0, 2'b10, 1'b0);
        do_write(5'd13, 32'h0000_80F0, 2'b01, 1'b1);
        do_write(5'd14, 32'h0000_80F0, 2'b01, 1'b0);
        do_write(5'd15, 32'h8765_80F0, 2'b11, 1'b1);
        set_reads(5'd11, 5'd12);
        expect_val("byte_s", 0, 32'hFFFF_FFF0);
        expect_val("byte_u", 1, 32'h0000_00F0);
        check_now();
        set_reads(5'd13, 5'd14);
        expect_val("half_s", 0, 32'hFFFF_80F0);
        expect_val("half_u", 1, 32'h0000_80F0);
        check_now();
        set_reads(5'd15, 5'd8);
        expect_val("size11_word", 0, 32'h8765_80F0);
        expect_val("r8_kept", 1, 32'hDEADBEEF);
        expect_val("size_wbr", 3, 32'd15);
        check_now();

        // $zero
        do_write(5'd0, 32'h1234, 2'b00, 1'b0);
        set_reads(5'd0, 5'd0);
        expect_val("zero_rd1", 0, 32'd0);
        expect_val("zero_rd2", 1, 32'd0);
        expect_val("zero_wbv", 2, 32'd0);
        expect_val("zero_wbr_hold", 3, 32'd15);
        check_now();

        // same-cycle read-after-write
        do_write(5'd9, 32'h11, 2'b00, 1'b0);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h55;
        write_size = 2'b00;
        set_reads(5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        expect_val("raw_before", 1, 32'h55);
`else
        expect_val("raw_before", 1, 32'h11);
`endif
        check_now();
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        expect_val("raw_after", 1, 32'h55);
        check_now();

        // reg_write held over consecutive edges
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd16;
        write_data = 32'hA5A5_0016;
        @(posedge clk);
        @(negedge clk);
        write_reg  = 5'd17;
        write_data = 32'hA5A5_0017;
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        set_reads(5'd16, 5'd17);
        expect_val("b2b_r16", 0, 32'hA5A5_0016);
        expect_val("b2b_r17", 1, 32'hA5A5_0017);
        expect_val("b2b_wbr", 3, 32'd17);
        check_now();

        // async reset in the middle of a pending write
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 32'hABCD;
        write_size = 2'b00;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        set_reads(5'd10, 5'd29);
        expect_val("mid_rst_r10", 0, 32'd0);
        expect_val("mid_rst_sp", 1, 32'd227);
        expect_val("mid_rst_wbv", 2, 32'd0);
        check_now();
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        expect_val("post_rst_r10", 0, 32'hABCD);
        expect_val("post_rst_wbv", 2, 32'd1);
        expect_val("post_rst_wbr", 3, 32'd10);
        check_now();

        begin
            int budget = 100;
            while (q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (q.size() > 0) begin
                mismatched++;
                $display("FAIL drain pending=%0d required=0", q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
